alu_bist_ctrl: RTL

- Hardware self-test initiator for the 4-bit ALU (`main_circuit`): drives the ALU's `s`/`a`/`b` inputs and checks all of its outputs.
- Sweeps all 1024 `{s,a,b}` combinations, waits a programmable settle time per vector, compares every output against built-in golden arithmetic, and counts mismatches.
- Replaces bench-only stimulus so the ALU can be tested on silicon. Sits beside the ALU; its `a_o`/`b_o`/`s_o` outputs feed the ALU inputs and the ALU outputs return to its `*_i` ports.

---
 rtl/alu_bist_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/alu_bist_ctrl.sv
// Self-test initiator for the 4-bit ALU: sweeps all 1024 {s,a,b} vectors and checks every output against golden arithmetic.
// Define ALU_BIST_FIRST_FAIL_EN to capture the index and field mask of the first failing vector.
module alu_bist_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [1:0]       s_o,
  output logic [3:0]       a_o,
  output logic [3:0]       b_o,
  input  logic [4:0]       adder_i,
  input  logic [4:0]       subs_i,
  input  logic [2:0]       comp_i,
  input  logic [3:0]       and_i,
  input  logic [3:0]       d_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [9:0]       first_fail,
  output logic [4:0]       fail_mask
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [3:0]       CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [9:0]       idx_q, idx_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic [1:0] s_v;
  logic [3:0] a_v, b_v;
  logic [4:0] exp_adder, exp_subs;
  logic [2:0] exp_comp;
  logic [3:0] exp_and, exp_d;
  logic [4:0] mask;
  logic       mismatch;
  logic       launch;
  logic       first_hit;

  assign s_v = idx_q[9:8];
  assign a_v = idx_q[7:4];
  assign b_v = idx_q[3:0];

  always_comb begin
    exp_adder = {1'b0, a_v} + {1'b0, b_v};
    exp_subs  = {1'b0, a_v} - {1'b0, b_v};
    exp_comp  = {a_v > b_v, a_v == b_v, a_v < b_v};
    exp_and   = a_v & b_v;
    exp_d     = 4'b0001 << s_v;
    mask      = {d_i != exp_d, and_i != exp_and, comp_i != exp_comp,
                 subs_i != exp_subs, adder_i != exp_adder};
    mismatch  = |mask;
  end

  // In DONE, busy is still high for the single cycle before done rises; start is ignored there.
  assign launch    = start && ((state_q == IDLE) || (state_q == DONE && !busy_q));
  // err_q only leaves zero on the first mismatch of a sweep, so it doubles as the "no failure yet" flag.
  assign first_hit = (state_q == CHECK) && mismatch && (err_q == '0);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    if (launch) begin
      state_d = SETTLE;
      idx_d   = '0;
      cnt_d   = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      err_d   = '0;
    end else begin
      case (state_q)
        SETTLE: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = CHECK;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        CHECK: begin
          if (mismatch && err_q != ERR_MAX) err_d = err_q + 1'b1;
          if (idx_q == 10'h3FF) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 10'd1;
            state_d = SETTLE;
          end
        end
        DONE: begin
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = (err_q == '0);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
    end
  end

`ifdef ALU_BIST_FIRST_FAIL_EN
  logic [9:0] ff_q, ff_d;
  logic [4:0] fm_q, fm_d;

  always_comb begin
    ff_d = ff_q;
    fm_d = fm_q;
    if (launch) begin
      ff_d = '0;
      fm_d = '0;
    end else if (first_hit) begin
      ff_d = idx_q;
      fm_d = mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_q <= '0;
      fm_q <= '0;
    end else begin
      ff_q <= ff_d;
      fm_q <= fm_d;
    end
  end

  assign first_fail = ff_q;
  assign fail_mask  = fm_q;
`else
  logic unused_first_hit;
  assign unused_first_hit = first_hit;
  assign first_fail       = '0;
  assign fail_mask        = '0;
`endif

  assign s_o       = s_v;
  assign a_o       = a_v;
  assign b_o       = b_v;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;

endmodule
